// File: rtl/plab5_mcore_net_resp_unpack_buf_if.sv
// Core-side response port bundle: split network message in, memory response out.
// The environment side (network + core) is the master; the unpack buffer is the slave.
interface plab5_mcore_net_resp_unpack_buf_if #(
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3
);
    localparam int mcn = p_mem_opaque_nbits + 5;
    localparam int ncn = mcn + p_net_opaque_nbits + 2 * p_net_srcdest_nbits;

    // Handshake: a transfer happens on a rising clk edge where val && rdy;
    // rdy never depends on val, and val/payload hold until the transfer.
    logic                        in_domain;
    logic [ncn-1:0]              in_msg_control;
    logic [p_mem_data_nbits-1:0] in_msg_data;
    logic                        in_val;
    logic                        in_rdy;
    logic                        out_domain;
    logic [mcn-1:0]              out_msg_control;
    logic [p_mem_data_nbits-1:0] out_msg_data;
    logic                        out_val;
    logic                        out_rdy;

    modport master (
        output in_domain, in_msg_control, in_msg_data, in_val, out_rdy,
        input  in_rdy, out_domain, out_msg_control, out_msg_data, out_val
    );

    modport slave (
        input  in_domain, in_msg_control, in_msg_data, in_val, out_rdy,
        output in_rdy, out_domain, out_msg_control, out_msg_data, out_val
    );
endinterface

// File: rtl/plab5_mcore_net_resp_unpack_buf.sv
// Strips the network header off memory responses, drops misrouted ones, and buffers the rest.
// Optional macro PLAB5_NET_RESP_MISROUTE_CNT_EN adds a saturating misroute_cnt output.
module plab5_mcore_net_resp_unpack_buf #(
    parameter int p_core_id           = 0,
    parameter int p_num_entries       = 2,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3
) (
    input  logic clk,
    input  logic reset,
    plab5_mcore_net_resp_unpack_buf_if.slave bus,
    output logic err_misroute
`ifdef PLAB5_NET_RESP_MISROUTE_CNT_EN
    ,
    output logic [7:0] misroute_cnt
`endif
);
    localparam int mcn   = p_mem_opaque_nbits + 5;
    localparam int ns    = p_net_srcdest_nbits;
    localparam int ncn   = mcn + p_net_opaque_nbits + 2 * ns;
    localparam int md    = p_mem_data_nbits;
    localparam int ptr_w = $clog2(p_num_entries);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [ns-1:0] core_id = ns'(p_core_id);

    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;

    logic [mcn-1:0] ctrl_mem [p_num_entries];
    logic [md-1:0]  data_mem [p_num_entries];
    logic           dom_mem  [p_num_entries];

    logic [ns-1:0] dest;
    logic          full;
    logic          in_xfer;
    logic          route_ok;
    logic          enq;
    logic          deq;
    logic          misroute_evt;
    logic          unused_hdr;

    assign dest         = bus.in_msg_control[ncn-1 -: ns];
    assign full         = (count == cnt_w'(p_num_entries));
    assign bus.in_rdy   = !full;
    assign in_xfer      = bus.in_val && bus.in_rdy;
    assign route_ok     = (dest == core_id);
    assign enq          = in_xfer && route_ok;
    assign misroute_evt = in_xfer && !route_ok;
    assign deq          = bus.out_val && bus.out_rdy;

    // src and network opaque are discarded once the message is accepted.
    assign unused_hdr = ^bus.in_msg_control[ncn-ns-1:mcn];

    // Storage is not reset; stale entries are masked by out_val.
    always_ff @(posedge clk) begin
        if (enq) begin
            ctrl_mem[wr_ptr] <= bus.in_msg_control[mcn-1:0];
            data_mem[wr_ptr] <= bus.in_msg_data;
            dom_mem[wr_ptr]  <= bus.in_domain;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_misroute <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
            err_misroute <= misroute_evt;
        end
    end

`ifdef PLAB5_NET_RESP_MISROUTE_CNT_EN
    // Counts on the same edge that raises err_misroute, so both are visible together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misroute_cnt <= '0;
        end else if (misroute_evt && (misroute_cnt != 8'hFF)) begin
            misroute_cnt <= misroute_cnt + 8'd1;
        end
    end
`endif

    // Data and domain are zeroed when empty so high-domain data never leaks.
    assign bus.out_val         = (count != '0);
    assign bus.out_msg_control = ctrl_mem[rd_ptr];
    assign bus.out_msg_data    = bus.out_val ? data_mem[rd_ptr] : '0;
    assign bus.out_domain      = bus.out_val ? dom_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_plab5_mcore_net_resp_unpack_buf.sv
// Bench for plab5_mcore_net_resp_unpack_buf: vector table, corner sequences, scoreboard.
module tb_plab5_mcore_net_resp_unpack_buf;
    localparam int W = 1 + 13 + 32;

    logic clk;
    logic reset;
    logic err_misroute;
`ifdef PLAB5_NET_RESP_MISROUTE_CNT_EN
    logic [7:0] misroute_cnt;
`endif

    plab5_mcore_net_resp_unpack_buf_if #(
        .p_mem_opaque_nbits(8), .p_mem_data_nbits(32),
        .p_net_opaque_nbits(4), .p_net_srcdest_nbits(3)
    ) bus ();

    plab5_mcore_net_resp_unpack_buf #(
        .p_core_id(0), .p_num_entries(2),
        .p_mem_opaque_nbits(8), .p_mem_data_nbits(32),
        .p_net_opaque_nbits(4), .p_net_srcdest_nbits(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .err_misroute(err_misroute)
`ifdef PLAB5_NET_RESP_MISROUTE_CNT_EN
        ,
        .misroute_cnt(misroute_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic acc_mis = 1'b0;
    logic model_mis;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(posedge clk or posedge reset) begin
        if (reset) model_mis <= 1'b0;
        else       model_mis <= acc_mis;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("err_misroute_pulse", 64'(err_misroute), 64'(model_mis));
            if (!bus.out_val) begin
                chk("empty_masked", {31'd0, bus.out_domain, bus.out_msg_data}, 64'd0);
            end else if (bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected none",
                             {bus.out_domain, bus.out_msg_control, bus.out_msg_data});
                end else begin
                    chk("sb_entry", 64'({bus.out_domain, bus.out_msg_control, bus.out_msg_data}),
                        64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] dest, input logic dom, input logic [12:0] pctl,
                        input logic [31:0] data, output int waited);
        logic [2:0] src;
        logic [3:0] nop;
        src = 3'($urandom_range(0, 7));
        nop = 4'($urandom_range(0, 15));
        bus.in_val         = 1'b1;
        bus.in_domain      = dom;
        bus.in_msg_control = {dest, src, nop, pctl};
        bus.in_msg_data    = data;
        waited = 0;
        @(negedge clk);
        while (!bus.in_rdy && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_rdy stayed %0b expected 1", bus.in_rdy);
        end else if (dest == 3'd0) begin
            exp_q.push_back({dom, pctl, data});
        end else begin
            acc_mis = 1'b1;
        end
        @(posedge clk);
        #1;
        acc_mis    = 1'b0;
        bus.in_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_rdy = 1'b1;
        while ((exp_q.size() != 0 || bus.out_val) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_q_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_val", 64'(bus.out_val), 64'd0);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_out_val", 64'(bus.out_val), 64'd0);
        chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
        chk("rst_out_data", 64'(bus.out_msg_data), 64'd0);
        chk("rst_err", 64'(err_misroute), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  dest;
        logic        dom;
        logic [2:0]  typ;
        logic [7:0]  opq;
        logic [1:0]  len;
        logic [31:0] data;
        logic        rdy;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int w;
        logic [12:0] pctl;

        vecs[0] = '{3'd0, 1'b0, 3'd1, 8'h11, 2'd1, 32'hA5A5_0001, 1'b1, 1'b0};
        vecs[1] = '{3'd5, 1'b1, 3'd2, 8'h22, 2'd2, 32'hA5A5_0002, 1'b1, 1'b1};
        vecs[2] = '{3'd0, 1'b1, 3'd7, 8'hFF, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{3'd0, 1'b0, 3'd0, 8'h00, 2'd0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{3'd7, 1'b0, 3'd3, 8'h44, 2'd1, 32'h1234_5678, 1'b0, 1'b1};
        vecs[5] = '{3'd0, 1'b1, 3'd4, 8'h80, 2'd2, 32'h8000_0000, 1'b1, 1'b0};
        vecs[6] = '{3'd1, 1'b1, 3'd5, 8'h66, 2'd0, 32'h6666_6666, 1'b0, 1'b1};
        vecs[7] = '{3'd0, 1'b0, 3'd6, 8'h7E, 2'd3, 32'h0BAD_F00D, 1'b1, 1'b0};

        bus.in_val = 1'b0;
        bus.in_domain = 1'b0;
        bus.in_msg_control = '0;
        bus.in_msg_data = '0;
        bus.out_rdy = 1'b1;
        reset = 1'b1;
        #2;
        chk("init_out_val", 64'(bus.out_val), 64'd0);
        chk("init_in_rdy", 64'(bus.in_rdy), 64'd1);
        chk("init_out_data", 64'(bus.out_msg_data), 64'd0);
        chk("init_err", 64'(err_misroute), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single message: visible one cycle after acceptance, then gone.
        send(3'd0, 1'b1, {3'd0, 8'h05, 2'd0}, 32'hDEADBEEF, w);
        chk("single_out_val", 64'(bus.out_val), 64'd1);
        chk("single_ctrl", 64'(bus.out_msg_control), 64'({3'd0, 8'h05, 2'd0}));
        chk("single_data", 64'(bus.out_msg_data), 64'hDEADBEEF);
        chk("single_dom", 64'(bus.out_domain), 64'd1);
        @(posedge clk);
        #1;
        chk("single_after_val", 64'(bus.out_val), 64'd0);
        chk("single_after_data", 64'(bus.out_msg_data), 64'd0);

        // Fill and backpressure.
        bus.out_rdy = 1'b0;
        send(3'd0, 1'b0, 13'h0A1, 32'd1, w);
        chk("fill_rdy_after1", 64'(bus.in_rdy), 64'd1);
        send(3'd0, 1'b0, 13'h0A2, 32'd2, w);
        chk("fill_rdy_after2", 64'(bus.in_rdy), 64'd0);
        fork
            begin
                int w3;
                send(3'd0, 1'b0, 13'h0A3, 32'd3, w3);
                checks++;
                if (w3 < 3) begin
                    errors++;
                    $display("FAIL fill_third_stall: waited %0d expected >= 3", w3);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("fill_stalled_rdy", 64'(bus.in_rdy), 64'd0);
                chk("fill_head_data", 64'(bus.out_msg_data), 64'd1);
                bus.out_rdy = 1'b1;
            end
        join
        drain();

        // Simultaneous enqueue/dequeue with one entry resident.
        bus.out_rdy = 1'b0;
        send(3'd0, 1'b1, 13'h100, 32'h10, w);
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 1'(i), 13'(12'h200 + i), 32'h20 + 32'(i), w);
            chk("simul_no_stall", 64'(w), 64'd0);
        end
        chk("simul_count_one", 64'(bus.out_val), 64'd1);
        drain();

        // Mixed domains back to back.
        bus.out_rdy = 1'b0;
        send(3'd0, 1'b0, 13'h011, 32'h1111, w);
        send(3'd0, 1'b1, 13'h022, 32'h2222, w);
        chk("mix_head_dom", 64'(bus.out_domain), 64'd0);
        chk("mix_head_data", 64'(bus.out_msg_data), 64'h1111);
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("mix_next_dom", 64'(bus.out_domain), 64'd1);
        chk("mix_next_data", 64'(bus.out_msg_data), 64'h2222);
        drain();

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            bus.out_rdy = vecs[i].rdy;
            pctl = {vecs[i].typ, vecs[i].opq, vecs[i].len};
            send(vecs[i].dest, vecs[i].dom, pctl, vecs[i].data, w);
            chk("vec_err_misroute", 64'(err_misroute), 64'(vecs[i].exp_mis));
        end
        drain();

        // Reset with two entries queued.
        bus.out_rdy = 1'b0;
        send(3'd0, 1'b1, 13'h1F0, 32'h5555_AAAA, w);
        send(3'd0, 1'b1, 13'h1F1, 32'hAAAA_5555, w);
        chk("pre_rst_full", 64'(bus.in_rdy), 64'd0);
        pulse_reset();
        bus.out_rdy = 1'b1;
        send(3'd0, 1'b1, 13'h0C0, 32'hCAFE_0001, w);
        chk("post_rst_val", 64'(bus.out_val), 64'd1);
        chk("post_rst_data", 64'(bus.out_msg_data), 64'hCAFE_0001);
        drain();

        // Misroute: consumed, one-cycle pulse, nothing queued.
        pulse_reset();
        send(3'd3, 1'b1, 13'h0EE, 32'hBAD0_BAD0, w);
        chk("mis_consumed", 64'(w), 64'd0);
        chk("mis_pulse", 64'(err_misroute), 64'd1);
        chk("mis_out_val", 64'(bus.out_val), 64'd0);
`ifdef PLAB5_NET_RESP_MISROUTE_CNT_EN
        chk("mis_cnt_one", 64'(misroute_cnt), 64'd1);
`endif
        @(posedge clk);
        #1;
        chk("mis_pulse_end", 64'(err_misroute), 64'd0);
        chk("mis_out_val2", 64'(bus.out_val), 64'd0);
`ifdef PLAB5_NET_RESP_MISROUTE_CNT_EN
        for (int i = 0; i < 299; i++) begin
            send(3'($urandom_range(1, 7)), 1'b0, 13'h0, 32'(i), w);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("mis_cnt_sat", 64'(misroute_cnt), 64'hFF);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
